// File: rtl/spi_regbank_pkg.sv
// Shared types for the SPI command register bank.
// SPI_REGBANK_PARITY_EN turns on even-parity framing.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_RW  = 2'd0,
    CLS_RO  = 2'd1,
    CLS_STS = 2'd2,
    CLS_INV = 2'd3
  } addr_cls_t;

  // Default geometry: 1 W/OK bit, 1 P/ERR bit, ADDR, DATA.
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_FRAME_W = 2 + DEF_ADDR_W + DEF_DATA_W;
  localparam int W_BIT       = DEF_FRAME_W - 1;
  localparam int P_BIT       = DEF_FRAME_W - 2;
  localparam int ADDR_LSB    = DEF_DATA_W;

  localparam logic [DEF_ADDR_W-1:0] STATUS_ADDR = '1;

`ifdef SPI_REGBANK_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int status_addr(input int aw);
    return (2 ** aw) - 1;
  endfunction

endpackage

// File: rtl/spi_regbank_decode.sv
// Command field split, address class and parity check.
// Parity is only acted on with SPI_REGBANK_PARITY_EN.
module spi_regbank_decode
  import spi_regbank_pkg::*;
#(
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NUM_RW  = 8,
  localparam int FRAME_W = 2 + ADDR_W + DATA_W
) (
  input  logic [FRAME_W-1:0] cmd,
  output logic               is_wr,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  data,
  output addr_cls_t          cls,
  output logic               par_ok
);
  localparam int STS = status_addr(ADDR_W);

  assign is_wr  = cmd[FRAME_W-1];
  assign addr   = cmd[DATA_W +: ADDR_W];
  assign data   = cmd[DATA_W-1:0];
  assign par_ok = ~^cmd;

  always_comb begin
    cls = CLS_INV;
    unique case (1'b1)
      (addr < ADDR_W'(NUM_RW)):
        cls = CLS_RW;
      (addr == ADDR_W'(STS)):
        cls = CLS_STS;
      (addr >= ADDR_W'(NUM_RW)
        && addr < ADDR_W'(STS)):
        cls = CLS_RO;
      default:
        cls = CLS_INV;
    endcase
  end

endmodule

// File: rtl/spi_register_bank.sv
// SPI command decoder and register file, one command per frame.
// SPI_REGBANK_PARITY_EN: P bit is even parity, ERR shown as OK=0.
module spi_register_bank
  import spi_regbank_pkg::*;
#(
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NUM_RW  = 8,
  localparam int FRAME_W = 2 + ADDR_W + DATA_W,
  localparam int NUM_RO  = (2 ** ADDR_W) - 1 - NUM_RW
) (
  input  logic                     system_clk,
  input  logic                     system_rst_n,
  input  logic [FRAME_W-1:0]       value_mosi,
  input  logic                     value_valid,
  input  logic                     cs_start,
  input  logic                     cs_stop,
  output logic [FRAME_W-1:0]       value_miso,
  output logic [NUM_RW*DATA_W-1:0] reg_out,
  input  logic [NUM_RO*DATA_W-1:0] ro_in,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr
);
  localparam int CNT_W = DATA_W / 2;

  localparam logic [FRAME_W-1:0] ABORT_RESP =
    {1'b0, ~PARITY_EN, {(ADDR_W+DATA_W){1'b0}}};

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] cmd, pending, resp;
  logic [DATA_W-1:0]  regs [NUM_RW];
  logic [CNT_W-1:0]   err_cnt, abt_cnt;
  logic [DATA_W-1:0]  frm_cnt;
  logic               latch, abort, drop;
  logic               is_wr, par_ok;
  logic               ok, err, wr_ok;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data, rd_data;
  addr_cls_t          cls;
  logic               exec, wr_en, exec_err;
  logic [1:0]         err_inc;
  logic [CNT_W:0]     err_sum;

  spi_regbank_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_RW (NUM_RW)
  ) u_decode (
    .cmd    (cmd),
    .is_wr  (is_wr),
    .addr   (addr),
    .data   (data),
    .cls    (cls),
    .par_ok (par_ok)
  );

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    abort     = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (value_valid) begin
          latch     = 1'b1;
          state_nxt = EXEC;
        end else if (cs_stop) begin
          abort = 1'b1;
        end
      end
      EXEC: begin
        drop      = value_valid;
        state_nxt = RESP;
      end
      RESP: begin
        drop      = value_valid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ok      = 1'b0;
    err     = 1'b0;
    wr_ok   = 1'b0;
    rd_data = '0;
    if (PARITY_EN && !par_ok) begin
      err = 1'b1;
    end else if (is_wr) begin
      if (cls == CLS_RW) begin
        wr_ok   = 1'b1;
        ok      = 1'b1;
        rd_data = data;
      end else begin
        err = 1'b1;
      end
    end else begin
      ok = 1'b1;
      unique case (cls)
        CLS_RW:
          for (int k = 0; k < NUM_RW; k++)
            if (addr == ADDR_W'(k))
              rd_data = regs[k];
        CLS_RO:
          for (int k = 0; k < NUM_RO; k++)
            if (addr == ADDR_W'(NUM_RW + k))
              rd_data = ro_in[k*DATA_W +: DATA_W];
        CLS_STS:
          rd_data = {abt_cnt, err_cnt};
        default: begin
          ok  = 1'b0;
          err = 1'b1;
        end
      endcase
    end
  end

`ifdef SPI_REGBANK_PARITY_EN
  assign resp =
    {ok, ^{ok, addr, rd_data}, addr, rd_data};
`else
  assign resp = {ok, err, addr, rd_data};
`endif

  assign exec     = (state == EXEC);
  assign wr_en    = exec & wr_ok;
  assign exec_err = exec & err;
  assign err_inc  = {1'b0, exec_err} + {1'b0, drop};
  assign err_sum  = {1'b0, err_cnt}
                  + {{(CNT_W-1){1'b0}}, err_inc};

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      pending    <= '0;
      value_miso <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      err_cnt    <= '0;
      abt_cnt    <= '0;
      frm_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      wr_strobe <= wr_en;
      if (latch)
        cmd <= value_mosi;
      if (wr_en)
        wr_addr <= addr;
      // miso tracks pending so it is ready when cs_start samples it
      if (exec) begin
        frm_cnt    <= frm_cnt + 1'b1;
        pending    <= resp;
        value_miso <= resp;
      end else if (abort) begin
        pending    <= ABORT_RESP;
        value_miso <= ABORT_RESP;
      end else if (cs_start) begin
        value_miso <= pending;
      end
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      if (abort && !(&abt_cnt))
        abt_cnt <= abt_cnt + 1'b1;
    end
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      for (int k = 0; k < NUM_RW; k++)
        regs[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_RW; k++)
        if (wr_en && addr == ADDR_W'(k))
          regs[k] <= data;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_RW; k++)
      reg_out[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule
